mem_port_arbiter: RTL and testbench

Arbitrates the shared external memory between the CoreSystem DMA read path and the CPU write path. Each requester gets a one-entry holding register with a valid/ready handshake. At most one memory command (read or write) is issued per cycle. The block enforces write-before-read ordering on same-address conflicts and returns read data to the core with a valid strobe. It sits between CoreSystem_ahb3lite_top / CPU_ahb3lite_top and ahb3lite_memory, replacing the direct wiring of the memory read and write ports.

---
 rtl/mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one external memory between the CoreSystem DMA read path and the
//   CPU write path. Each requester owns a one-entry holding register that is
//   loaded through a valid/ready handshake. At most one memory command, read
//   or write, leaves the block per cycle. When a held read and a held write
//   target the same address, the write always goes first. Read data returns
//   to the core one cycle after the memory strobe, qualified by
//   core_rd_valid.
//
// Configuration macro:
//   ARB_RR_EN  defined   : round-robin between read and write when they
//                          contend on different addresses
//              undefined : fixed priority, read wins on different-address
//                          contention
//
// Parameters:
//   ADDR_W  address width of both requesters and the memory
//   DATA_W  data width
//   CNT_W   width of the saturating conflict counter
//
// Ports:
//   HCLK            in   clock, rising edge
//   HRESET          in   synchronous active-high reset
//   core_rd_req     in   core read request valid
//   core_rd_addr    in   core read address
//   core_rd_ready   out  core read request accepted when req & ready
//   core_rd_data    out  read data returned to the core (pass-through)
//   core_rd_valid   out  core_rd_data valid this cycle
//   cpu_wr_req      in   CPU write request valid
//   cpu_wr_addr     in   CPU write address
//   cpu_wr_data     in   CPU write data
//   cpu_wr_ready    out  CPU write request accepted when req & ready
//   mem_READ_addr   out  registered memory read address
//   mem_read_flag   out  registered memory read strobe
//   HRDATA_fromMem  in   memory read data, one cycle after mem_read_flag
//   mem_WRITE_addr  out  registered memory write address
//   mem_write_flag  out  registered memory write strobe
//   HWDATA_toMem    out  registered memory write data
//   conflict_cnt    out  saturating count of cycles with both holds valid
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,

    input  logic              core_rd_req,
    input  logic [ADDR_W-1:0] core_rd_addr,
    output logic              core_rd_ready,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_rd_valid,

    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_ready,

    output logic [ADDR_W-1:0] mem_READ_addr,
    output logic              mem_read_flag,
    input  logic [DATA_W-1:0] HRDATA_fromMem,
    output logic [ADDR_W-1:0] mem_WRITE_addr,
    output logic              mem_write_flag,
    output logic [DATA_W-1:0] HWDATA_toMem,

    output logic [CNT_W-1:0]  conflict_cnt
);

    // Saturating increment for the conflict statistics counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    // Holding registers
    logic              rd_hold_valid;
    logic [ADDR_W-1:0] rd_hold_addr;
    logic              wr_hold_valid;
    logic [ADDR_W-1:0] wr_hold_addr;
    logic [DATA_W-1:0] wr_hold_data;

    // Arbitration
    logic both_valid;
    logic same_addr;
    logic grant_rd;
    logic grant_wr;

    // Handshake
    logic rd_accept;
    logic wr_accept;

    // Read return tracking
    logic rd_pending;

`ifdef ARB_RR_EN
    // 0: read was issued last, 1: write was issued last. Resets to 1 so the
    // first different-address contention after reset goes to the read.
    logic last_grant;
`endif

    assign both_valid = rd_hold_valid & wr_hold_valid;
    assign same_addr  = (rd_hold_addr == wr_hold_addr);

    // -----------------------------------------------------------------------
    // Stage 0: combinational grant on the hold contents
    // -----------------------------------------------------------------------
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (both_valid) begin
            if (same_addr) begin
                // Write-before-read on a same-address hazard, regardless of
                // the contention policy, so the read observes the new data.
                grant_wr = 1'b1;
            end else begin
`ifdef ARB_RR_EN
                if (last_grant) begin
                    grant_rd = 1'b1;
                end else begin
                    grant_wr = 1'b1;
                end
`else
                grant_rd = 1'b1;
`endif
            end
        end else if (rd_hold_valid) begin
            grant_rd = 1'b1;
        end else if (wr_hold_valid) begin
            grant_wr = 1'b1;
        end
    end

    // A hold that is being issued this cycle can take a new request in the
    // same edge, which gives one request per cycle to a granted requester.
    assign core_rd_ready = ~rd_hold_valid | grant_rd;
    assign cpu_wr_ready  = ~wr_hold_valid | grant_wr;

    assign rd_accept = core_rd_req & core_rd_ready;
    assign wr_accept = cpu_wr_req  & cpu_wr_ready;

    // -----------------------------------------------------------------------
    // Hold registers: load on accept, clear on issue
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_hold_valid <= 1'b0;
        end else if (rd_accept) begin
            rd_hold_valid <= 1'b1;
        end else if (grant_rd) begin
            rd_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (rd_accept) begin
            rd_hold_addr <= core_rd_addr;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_hold_valid <= 1'b0;
        end else if (wr_accept) begin
            wr_hold_valid <= 1'b1;
        end else if (grant_wr) begin
            wr_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_accept) begin
            wr_hold_addr <= cpu_wr_addr;
            wr_hold_data <= cpu_wr_data;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            last_grant <= 1'b1;
        end else if (grant_rd) begin
            last_grant <= 1'b0;
        end else if (grant_wr) begin
            last_grant <= 1'b1;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Stage 1: registered memory command
    // -----------------------------------------------------------------------
    // Strobes follow the grant every cycle; address and data only move when
    // their command issues and otherwise keep the last issued value.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mem_read_flag  <= 1'b0;
            mem_write_flag <= 1'b0;
        end else begin
            mem_read_flag  <= grant_rd;
            mem_write_flag <= grant_wr;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mem_READ_addr <= '0;
        end else if (grant_rd) begin
            mem_READ_addr <= rd_hold_addr;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mem_WRITE_addr <= '0;
            HWDATA_toMem   <= '0;
        end else if (grant_wr) begin
            mem_WRITE_addr <= wr_hold_addr;
            HWDATA_toMem   <= wr_hold_data;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: read return, memory data arrives one cycle after the strobe
    // -----------------------------------------------------------------------
    // Clearing rd_pending on reset drops a read that was in flight, so no
    // stale core_rd_valid appears after reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= mem_read_flag;
        end
    end

    assign core_rd_valid = rd_pending;
    assign core_rd_data  = HRDATA_fromMem;

    // Conflict statistics
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            conflict_cnt <= '0;
        end else if (both_valid) begin
            conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter (CNT_W = 4). The bench plays the
// role of the external memory and keeps a transaction-level reference model
// of the arbiter: pending requests are queues, the grant is chosen from the
// arbitration rules, and the expected memory contents are tracked in an
// associative array. Directed scenarios add explicit constant expectations.
// Honours ARB_RR_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    logic          HCLK;
    logic          HRESET;
    logic          core_rd_req;
    logic [AW-1:0] core_rd_addr;
    logic          core_rd_ready;
    logic [DW-1:0] core_rd_data;
    logic          core_rd_valid;
    logic          cpu_wr_req;
    logic [AW-1:0] cpu_wr_addr;
    logic [DW-1:0] cpu_wr_data;
    logic          cpu_wr_ready;
    logic [AW-1:0] mem_READ_addr;
    logic          mem_read_flag;
    logic [DW-1:0] HRDATA_fromMem;
    logic [AW-1:0] mem_WRITE_addr;
    logic          mem_write_flag;
    logic [DW-1:0] HWDATA_toMem;
    logic [CW-1:0] conflict_cnt;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .core_rd_req    (core_rd_req),
        .core_rd_addr   (core_rd_addr),
        .core_rd_ready  (core_rd_ready),
        .core_rd_data   (core_rd_data),
        .core_rd_valid  (core_rd_valid),
        .cpu_wr_req     (cpu_wr_req),
        .cpu_wr_addr    (cpu_wr_addr),
        .cpu_wr_data    (cpu_wr_data),
        .cpu_wr_ready   (cpu_wr_ready),
        .mem_READ_addr  (mem_READ_addr),
        .mem_read_flag  (mem_read_flag),
        .HRDATA_fromMem (HRDATA_fromMem),
        .mem_WRITE_addr (mem_WRITE_addr),
        .mem_write_flag (mem_write_flag),
        .HWDATA_toMem   (HWDATA_toMem),
        .conflict_cnt   (conflict_cnt)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int ntests = 0;
    int nfail  = 0;

    // Memory as seen by the DUT (driven from the DUT's own strobes)
    logic [31:0] bmem [logic [31:0]];
    logic        p_rflag, p_wflag;
    logic [31:0] p_raddr, p_waddr, p_wdata;

    // Reference model
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] mrq [$];
    logic [31:0] mwa [$];
    logic [31:0] mwd [$];
    logic        m_rflag, m_wflag, m_rvalid;
    logic [31:0] m_raddr, m_waddr, m_wdata, m_rdata, m_issue_data;
    int          m_cnt;
`ifdef ARB_RR_EN
    bit          m_last_wr;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // 0 = nothing, 1 = read, 2 = write
    function automatic int m_grant();
        bit rh, wh;
        rh = (mrq.size() != 0);
        wh = (mwa.size() != 0);
        if (rh && wh) begin
            if (mrq[0] == mwa[0]) return 2;
`ifdef ARB_RR_EN
            return m_last_wr ? 1 : 2;
`else
            return 1;
`endif
        end
        if (rh) return 1;
        if (wh) return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        mrq.delete();
        mwa.delete();
        mwd.delete();
        m_rflag = 1'b0; m_wflag = 1'b0; m_rvalid = 1'b0;
        m_raddr = '0; m_waddr = '0; m_wdata = '0;
        m_rdata = '0; m_issue_data = '0;
        m_cnt = 0;
`ifdef ARB_RR_EN
        m_last_wr = 1'b1;
`endif
    endfunction

    function automatic void model_step(input logic rq, input logic [31:0] ra,
                                       input logic wq, input logic [31:0] wa,
                                       input logic [31:0] wd, input logic rst);
        int g;
        bit rdy_r, rdy_w;
        g = m_grant();
        rdy_r = (mrq.size() == 0) || (g == 1);
        rdy_w = (mwa.size() == 0) || (g == 2);
        if (rst) begin
            model_reset();
            return;
        end
        if (mrq.size() != 0 && mwa.size() != 0 && m_cnt < CNT_MAX) m_cnt++;
        m_rvalid = m_rflag;
        m_rdata  = m_issue_data;
        m_rflag  = (g == 1);
        m_wflag  = (g == 2);
        if (g == 1) begin
            m_raddr = mrq.pop_front();
            m_issue_data = rmem.exists(m_raddr) ? rmem[m_raddr] : 32'h0;
`ifdef ARB_RR_EN
            m_last_wr = 1'b0;
`endif
        end
        if (g == 2) begin
            m_waddr = mwa.pop_front();
            m_wdata = mwd.pop_front();
            rmem[m_waddr] = m_wdata;
`ifdef ARB_RR_EN
            m_last_wr = 1'b1;
`endif
        end
        if (rq && rdy_r) mrq.push_back(ra);
        if (wq && rdy_w) begin
            mwa.push_back(wa);
            mwd.push_back(wd);
        end
    endfunction

    task automatic check_outputs();
        int g;
        g = m_grant();
        chk("core_rd_ready", core_rd_ready, (mrq.size() == 0) || (g == 1));
        chk("cpu_wr_ready", cpu_wr_ready, (mwa.size() == 0) || (g == 2));
        chk("mem_read_flag", mem_read_flag, m_rflag);
        chk("mem_write_flag", mem_write_flag, m_wflag);
        chk("mem_READ_addr", mem_READ_addr, m_raddr);
        chk("mem_WRITE_addr", mem_WRITE_addr, m_waddr);
        chk("HWDATA_toMem", HWDATA_toMem, m_wdata);
        chk("core_rd_valid", core_rd_valid, m_rvalid);
        if (m_rvalid) chk("core_rd_data", core_rd_data, m_rdata);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        chk("flags_exclusive", mem_read_flag & mem_write_flag, 1'b0);
    endtask

    // One clock cycle: drive inputs after the edge, check at the falling
    // edge, then advance the reference model across the next rising edge.
    task automatic cycle(input logic rq, input logic [31:0] ra,
                         input logic wq, input logic [31:0] wa,
                         input logic [31:0] wd, input logic rst);
        @(posedge HCLK);
        #1;
        if (p_wflag) bmem[p_waddr] = p_wdata;
        if (p_rflag) HRDATA_fromMem = bmem.exists(p_raddr) ? bmem[p_raddr] : 32'h0;
        else         HRDATA_fromMem = $urandom;
        HRESET       = rst;
        core_rd_req  = rq;
        core_rd_addr = ra;
        cpu_wr_req   = wq;
        cpu_wr_addr  = wa;
        cpu_wr_data  = wd;
        @(negedge HCLK);
        check_outputs();
        p_rflag = mem_read_flag;
        p_raddr = mem_READ_addr;
        p_wflag = mem_write_flag;
        p_waddr = mem_WRITE_addr;
        p_wdata = HWDATA_toMem;
        model_step(rq, ra, wq, wa, wd, rst);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string seq;
        string exp_seq;
        int    rf_cnt, rv_cnt, rf_first, rf_last;

        HRESET = 1'b1;
        core_rd_req = 1'b0; core_rd_addr = '0;
        cpu_wr_req = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        HRDATA_fromMem = '0;
        p_rflag = 1'b0; p_wflag = 1'b0;
        p_raddr = '0; p_waddr = '0; p_wdata = '0;
        model_reset();

        // Reset state
        do_reset();
        do_reset();
        idle(1);
        chk("rst_rd_ready", core_rd_ready, 1'b1);
        chk("rst_wr_ready", cpu_wr_ready, 1'b1);
        chk("rst_rflag", mem_read_flag, 1'b0);
        chk("rst_wflag", mem_write_flag, 1'b0);
        chk("rst_raddr", mem_READ_addr, 32'h0);
        chk("rst_waddr", mem_WRITE_addr, 32'h0);
        chk("rst_wdata", HWDATA_toMem, 32'h0);
        chk("rst_rvalid", core_rd_valid, 1'b0);
        chk("rst_cnt", conflict_cnt, 4'd0);

        // Single read at 0x100
        bmem[32'h100] = 32'hDEADBEEF;
        rmem[32'h100] = 32'hDEADBEEF;
        cycle(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("single_accept", core_rd_ready, 1'b1);
        idle(1);
        chk("single_flag_c2", mem_read_flag, 1'b0);
        idle(1);
        chk("single_flag_c3", mem_read_flag, 1'b1);
        chk("single_addr", mem_READ_addr, 32'h100);
        idle(1);
        chk("single_flag_c4", mem_read_flag, 1'b0);
        chk("single_valid", core_rd_valid, 1'b1);
        chk("single_data", core_rd_data, 32'hDEADBEEF);
        idle(1);
        chk("single_valid_off", core_rd_valid, 1'b0);

        // Same-address hazard at 0x40
        cycle(1'b1, 32'h40, 1'b1, 32'h40, 32'h12345678, 1'b0);
        idle(1);
        chk("haz_rd_ready", core_rd_ready, 1'b0);
        chk("haz_wr_ready", cpu_wr_ready, 1'b1);
        idle(1);
        chk("haz_wflag", mem_write_flag, 1'b1);
        chk("haz_rflag0", mem_read_flag, 1'b0);
        chk("haz_waddr", mem_WRITE_addr, 32'h40);
        idle(1);
        chk("haz_rflag", mem_read_flag, 1'b1);
        chk("haz_wflag_off", mem_write_flag, 1'b0);
        idle(1);
        chk("haz_valid", core_rd_valid, 1'b1);
        chk("haz_data", core_rd_data, 32'h12345678);
        chk("haz_cnt", conflict_cnt, 4'd1);

        // Different-address contention held for 6 cycles
        do_reset();
        seq = "";
        for (int i = 0; i < 10; i++) begin
            if (i < 6) cycle(1'b1, 32'h10 + i, 1'b1, 32'h80 + i, 32'h5000 + i, 1'b0);
            else       idle(1);
            if (mem_read_flag)  seq = {seq, "R"};
            if (mem_write_flag) seq = {seq, "W"};
        end
`ifdef ARB_RR_EN
        exp_seq = "RWRWRWR";
`else
        exp_seq = "RRRRRRW";
`endif
        chk("contend_len", seq.len(), exp_seq.len());
        for (int i = 0; i < exp_seq.len(); i++) begin
            if (i < seq.len()) chk($sformatf("contend_%0d", i), seq[i], exp_seq[i]);
        end

        // Back-to-back reads, CPU idle
        rf_cnt = 0; rv_cnt = 0; rf_first = -1; rf_last = -1;
        for (int i = 0; i < 4; i++) begin
            bmem[32'h200 + i] = 32'hA0000000 + i;
            rmem[32'h200 + i] = 32'hA0000000 + i;
        end
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                cycle(1'b1, 32'h200 + i, 1'b0, 32'h0, 32'h0, 1'b0);
                chk($sformatf("b2b_ready_%0d", i), core_rd_ready, 1'b1);
            end else begin
                idle(1);
            end
            if (mem_read_flag) begin
                rf_cnt++;
                if (rf_first < 0) rf_first = i;
                rf_last = i;
            end
            if (core_rd_valid) rv_cnt++;
        end
        chk("b2b_rflag_cnt", rf_cnt, 4);
        chk("b2b_rflag_span", rf_last - rf_first, 3);
        chk("b2b_rvalid_cnt", rv_cnt, 4);

        // Reset mid-operation with a write still held
        cycle(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(1);
        cycle(1'b0, 32'h0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0);
        chk("rmid_rflag", mem_read_flag, 1'b1);
        do_reset();
        idle(1);
        chk("rmid_rvalid", core_rd_valid, 1'b0);
        chk("rmid_wflag", mem_write_flag, 1'b0);
        chk("rmid_rflag_off", mem_read_flag, 1'b0);
        chk("rmid_raddr", mem_READ_addr, 32'h0);
        chk("rmid_waddr", mem_WRITE_addr, 32'h0);
        chk("rmid_wdata", HWDATA_toMem, 32'h0);
        chk("rmid_cnt", conflict_cnt, 4'd0);
        chk("rmid_rd_ready", core_rd_ready, 1'b1);
        chk("rmid_wr_ready", cpu_wr_ready, 1'b1);
        idle(1);
        chk("rmid_wflag2", mem_write_flag, 1'b0);
        chk("rmid_rvalid2", core_rd_valid, 1'b0);

        // Counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'h300 + i, 1'b1, 32'h400 + i, 32'h9000 + i, 1'b0);
            if (i == 15) chk("sat_cnt_14", conflict_cnt, 4'd14);
        end
        idle(2);
        chk("sat_cnt_15", conflict_cnt, 4'd15);
        idle(12);
        chk("sat_cnt_hold", conflict_cnt, 4'd15);

        // Randomized traffic on a small address window to provoke hazards
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 60, 32'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 60, 32'($urandom_range(0, 7)),
                  $urandom, $urandom_range(0, 249) == 0);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
